mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS core. It sequences the shared datapath (PC, instruction/data memory port, register file, single ALU) through fetch, decode, execute, memory and writeback steps. It produces every mux select, write enable and ALU operation code, and waits on a memory-ready handshake. It sits between the instruction register's opcode/funct fields and the datapath, and also keeps a retired-instruction counter for debug.

## Interface
- Parameters: none.
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero_flag  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request, held until mem_ready
- mem_write  out  1  store enable, valid with mem_req
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- ir_write  out  1  load instruction register
- pc_en  out  1  PC write enable
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- alu_src_a  out  1  0 = PC, 1 = register A (rs)
- alu_src_b  out  2  00 B (rt), 01 const 4, 10 signimm, 11 signimm<<2
- alu_control  out  4  ALU operation code
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = data register
- reg_write  out  1  register-file write enable
- state  out  4  current state encoding (debug)
- instr_done  out  1  one-cycle pulse on last cycle of each instruction
- retired  out  32  count of completed instructions, wraps

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 are illegal and go to FETCH next cycle with all enables 0.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=ADD. When mem_ready=1, ir_write=1, pc_en=1, pc_src=00, then go to DECODE. Otherwise stay in FETCH with ir_write=pc_en=0.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target). Next state: lw/sw→MEMADR, R→EXEC, beq→BRANCH, addi→ADDIEX, j→JUMP. Any other opcode → FETCH with instr_done=1 and no writes (treated as NOP).
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Wait for mem_ready, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct: add 100000→0010, sub 100010→0110, and 100100→0000, or 100101→0001, xor 100110→0011, nor 100111→0100, slt 101010→0111, sll 000000→1000, srl 000010→1001, sra 000011→1010, sllv 000100→1011, srlv 000110→1100, srav 000111→1101. Unknown funct→0010.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH. reg_write is forced to 0 for an unknown funct.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_en=zero_flag → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- JUMP: pc_src=10, pc_en=1 → FETCH.
- Outputs not listed for a state: enables 0, selects 0, alu_control 0010.
- retired increments by 1 on every cycle with instr_done=1 and wraps from 0xFFFFFFFF to 0.

## Timing
- state and retired are registered. All other outputs decode combinationally from state; pc_en in BRANCH and FETCH also depends on zero_flag or mem_ready in the same cycle.
- instr_done=1 in: MEMWB, ALUWB (including unknown funct), ADDIWB, BRANCH, JUMP, MEMWR when mem_ready=1, and DECODE for an illegal opcode.
- Cycle counts with zero wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each cycle in which mem_ready=0 during a mem_req state adds one cycle.
- mem_req stays high and iord/mem_write stay stable until mem_ready. mem_ready is ignored outside FETCH/MEMRD/MEMWR.
- Reset: while rst_n=0, state=FETCH, retired=0, and all enables (mem_req, mem_write, ir_write, pc_en, reg_write, instr_done) are 0. Selects take their FETCH values.
- Asserting rst_n low in any state, including mid-wait, aborts the instruction immediately. No partial writes occur after assertion. The first fetch is on the first rising edge after deassertion.

## Test plan
- Reset, then an R-type add (opcode 0, funct 100000) with mem_ready tied 1 → states 0,1,6,7,0. alu_control=0010 in EXEC. reg_write=1 and reg_dst=1 in ALUWB. retired=1.
- lw with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4. mem_req/iord held. mem_to_reg=1 in MEMWB. Total 7 cycles.
- beq with zero_flag=1 and then zero_flag=0 → pc_en=1 and pc_src=01 in BRANCH for the first, pc_en=0 for the second. Both take 3 cycles.
- Sweep all 13 funct codes, plus funct 111111 → exact alu_control mapping. For 111111, alu_control=0010 and reg_write=0 in ALUWB, and retired still increments.
- Illegal opcode 111111 → DECODE→FETCH, instr_done=1, no writes. Separately, force retired to 0xFFFFFFFF, complete a j → retired=0.
- Drop rst_n during a MEMWR wait → mem_write=0 immediately, state=FETCH, retired=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Memory-port handshake between the multicycle control FSM and the shared
// instruction/data memory.
interface mips_multicycle_ctrl_if;
    logic mem_req;
    logic mem_write;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_write, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_write, input iord, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/
// execute/memory/writeback and counts retired instructions.
module mips_multicycle_ctrl (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [5:0]                   opcode,
    input  logic [5:0]                   funct,
    input  logic                         zero_flag,
    mips_multicycle_ctrl_if.master       mem,
    output logic                         ir_write,
    output logic                         pc_en,
    output logic [1:0]                   pc_src,
    output logic                         alu_src_a,
    output logic [1:0]                   alu_src_b,
    output logic [3:0]                   alu_control,
    output logic                         reg_dst,
    output logic                         mem_to_reg,
    output logic                         reg_write,
    output logic [3:0]                   state,
    output logic                         instr_done,
    output logic [31:0]                  retired
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;

    state_t     state_q, next_state;
    logic [3:0] exec_alu;
    logic       funct_known;
    logic       mem_req_c, mem_write_c, iord_c;

    always_comb begin
        funct_known = 1'b1;
        case (funct)
            6'b100000: exec_alu = 4'b0010;
            6'b100010: exec_alu = 4'b0110;
            6'b100100: exec_alu = 4'b0000;
            6'b100101: exec_alu = 4'b0001;
            6'b100110: exec_alu = 4'b0011;
            6'b100111: exec_alu = 4'b0100;
            6'b101010: exec_alu = 4'b0111;
            6'b000000: exec_alu = 4'b1000;
            6'b000010: exec_alu = 4'b1001;
            6'b000011: exec_alu = 4'b1010;
            6'b000100: exec_alu = 4'b1011;
            6'b000110: exec_alu = 4'b1100;
            6'b000111: exec_alu = 4'b1101;
            default: begin
                exec_alu    = ALU_ADD;
                funct_known = 1'b0;
            end
        endcase
    end

    always_comb begin
        next_state  = S_FETCH;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        iord_c      = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        instr_done  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alu_src_b = 2'b01;
                if (mem.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_en      = 1'b1;
                    next_state = S_DECODE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      instr_done = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req_c  = 1'b1;
                iord_c     = 1'b1;
                next_state = mem.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                instr_done  = mem.mem_ready;
                next_state  = mem.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = exec_alu;
                next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                // funct is held by the IR, so an unknown funct still retires but writes nothing
                reg_write  = funct_known;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_en       = zero_flag;
                instr_done  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
        // Reset holds state at FETCH, so only the enables need suppressing
        if (!rst_n) begin
            mem_req_c   = 1'b0;
            mem_write_c = 1'b0;
            ir_write    = 1'b0;
            pc_en       = 1'b0;
            reg_write   = 1'b0;
            instr_done  = 1'b0;
        end
    end

    assign mem.mem_req   = mem_req_c;
    assign mem.mem_write = mem_write_c;
    assign mem.iord      = iord_c;
    assign state         = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            retired <= '0;
        end else begin
            state_q <= next_state;
            if (instr_done) retired <= retired + 32'd1;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for the multicycle MIPS control FSM plus
// hand-written sequences for wait states, funct sweep, wrap and reset abort.
module tb_mips_multicycle_ctrl;
    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero_flag;
    logic        ir_write, pc_en, alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done;
    logic [1:0]  pc_src, alu_src_b;
    logic [3:0]  alu_control, state;
    logic [31:0] retired;
    int          checks;
    int          errors;
    logic [31:0] exp_ret;

    mips_multicycle_ctrl_if mem_bus ();

    mips_multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero_flag   (zero_flag),
        .mem         (mem_bus.master),
        .ir_write    (ir_write),
        .pc_en       (pc_en),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .state       (state),
        .instr_done  (instr_done),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zf;
        logic        mr;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic zf, input logic mr,
                       input logic [3:0] st, input logic mreq, input logic mwr, input logic iord,
                       input logic irw, input logic pcen, input logic [1:0] pcs, input logic asa,
                       input logic [1:0] asb, input logic [3:0] alu, input logic rdst,
                       input logic m2r, input logic rw, input logic done);
        vec_t v;
        v.op  = op;
        v.fn  = fn;
        v.zf  = zf;
        v.mr  = mr;
        v.exp = {st, mreq, mwr, iord, irw, pcen, pcs, asa, asb, alu, rdst, m2r, rw, done};
        vecs.push_back(v);
    endtask

    function automatic logic [21:0] outs();
        return {state, mem_bus.mem_req, mem_bus.mem_write, mem_bus.iord, ir_write, pc_en,
                pc_src, alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg, reg_write,
                instr_done};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_r(input logic [5:0] fn, input logic [3:0] alu, input logic rw);
        @(negedge clk);
        opcode = 6'b000000; funct = fn; mem_bus.mem_ready = 1'b1;
        #2 check("sweep_fetch", 64'(state), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 check($sformatf("sweep_exec_%b", fn), 64'({state, alu_control}), 64'({4'd6, alu}));
        @(negedge clk);
        #2 check($sformatf("sweep_wb_%b", fn), 64'({state, reg_write, instr_done}),
                 64'({4'd7, rw, 1'b1}));
        exp_ret = exp_ret + 32'd1;
        @(posedge clk);
        #1 check("sweep_retired", 64'(retired), 64'(exp_ret));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; exp_ret = '0;
        rst_n = 1'b0; opcode = '0; funct = '0; zero_flag = 1'b0; mem_bus.mem_ready = 1'b0;

        // fetch wait, then R add
        add(6'h00, 6'h20, 0, 0,  4'd0, 1,0,0,0,0, 2'b00, 0, 2'b01, 4'h2, 0,0,0,0);
        add(6'h00, 6'h20, 0, 1,  4'd0, 1,0,0,1,1, 2'b00, 0, 2'b01, 4'h2, 0,0,0,0);
        add(6'h00, 6'h20, 0, 1,  4'd1, 0,0,0,0,0, 2'b00, 0, 2'b11, 4'h2, 0,0,0,0);
        add(6'h00, 6'h20, 0, 1,  4'd6, 0,0,0,0,0, 2'b00, 1, 2'b00, 4'h2, 0,0,0,0);
        add(6'h00, 6'h20, 0, 1,  4'd7, 0,0,0,0,0, 2'b00, 0, 2'b00, 4'h2, 1,0,1,1);
        // lw with two wait cycles in MEMRD
        add(6'h23, 6'h00, 0, 1,  4'd0, 1,0,0,1,1, 2'b00, 0, 2'b01, 4'h2, 0,0,0,0);
        add(6'h23, 6'h00, 0, 1,  4'd1, 0,0,0,0,0, 2'b00, 0, 2'b11, 4'h2, 0,0,0,0);
        add(6'h23, 6'h00, 0, 1,  4'd2, 0,0,0,0,0, 2'b00, 1, 2'b10, 4'h2, 0,0,0,0);
        add(6'h23, 6'h00, 0, 0,  4'd3, 1,0,1,0,0, 2'b00, 0, 2'b00, 4'h2, 0,0,0,0);
        add(6'h23, 6'h00, 0, 0,  4'd3, 1,0,1,0,0, 2'b00, 0, 2'b00, 4'h2, 0,0,0,0);
        add(6'h23, 6'h00, 0, 1,  4'd3, 1,0,1,0,0, 2'b00, 0, 2'b00, 4'h2, 0,0,0,0);
        add(6'h23, 6'h00, 0, 1,  4'd4, 0,0,0,0,0, 2'b00, 0, 2'b00, 4'h2, 0,1,1,1);
        // sw
        add(6'h2B, 6'h00, 0, 1,  4'd0, 1,0,0,1,1, 2'b00, 0, 2'b01, 4'h2, 0,0,0,0);
        add(6'h2B, 6'h00, 0, 1,  4'd1, 0,0,0,0,0, 2'b00, 0, 2'b11, 4'h2, 0,0,0,0);
        add(6'h2B, 6'h00, 0, 1,  4'd2, 0,0,0,0,0, 2'b00, 1, 2'b10, 4'h2, 0,0,0,0);
        add(6'h2B, 6'h00, 0, 1,  4'd5, 1,1,1,0,0, 2'b00, 0, 2'b00, 4'h2, 0,0,0,1);
        // beq taken, then not taken
        add(6'h04, 6'h00, 1, 1,  4'd0, 1,0,0,1,1, 2'b00, 0, 2'b01, 4'h2, 0,0,0,0);
        add(6'h04, 6'h00, 1, 1,  4'd1, 0,0,0,0,0, 2'b00, 0, 2'b11, 4'h2, 0,0,0,0);
        add(6'h04, 6'h00, 1, 1,  4'd8, 0,0,0,0,1, 2'b01, 1, 2'b00, 4'h6, 0,0,0,1);
        add(6'h04, 6'h00, 0, 1,  4'd0, 1,0,0,1,1, 2'b00, 0, 2'b01, 4'h2, 0,0,0,0);
        add(6'h04, 6'h00, 0, 1,  4'd1, 0,0,0,0,0, 2'b00, 0, 2'b11, 4'h2, 0,0,0,0);
        add(6'h04, 6'h00, 0, 1,  4'd8, 0,0,0,0,0, 2'b01, 1, 2'b00, 4'h6, 0,0,0,1);
        // addi
        add(6'h08, 6'h00, 0, 1,  4'd0, 1,0,0,1,1, 2'b00, 0, 2'b01, 4'h2, 0,0,0,0);
        add(6'h08, 6'h00, 0, 1,  4'd1, 0,0,0,0,0, 2'b00, 0, 2'b11, 4'h2, 0,0,0,0);
        add(6'h08, 6'h00, 0, 1,  4'd9, 0,0,0,0,0, 2'b00, 1, 2'b10, 4'h2, 0,0,0,0);
        add(6'h08, 6'h00, 0, 1,  4'd10,0,0,0,0,0, 2'b00, 0, 2'b00, 4'h2, 0,0,1,1);
        // j
        add(6'h02, 6'h00, 0, 1,  4'd0, 1,0,0,1,1, 2'b00, 0, 2'b01, 4'h2, 0,0,0,0);
        add(6'h02, 6'h00, 0, 1,  4'd1, 0,0,0,0,0, 2'b00, 0, 2'b11, 4'h2, 0,0,0,0);
        add(6'h02, 6'h00, 0, 1,  4'd11,0,0,0,0,1, 2'b10, 0, 2'b00, 4'h2, 0,0,0,1);

        #12;
        check("reset_outs", 64'(outs()),
              64'({4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b01, 4'h2, 1'b0,1'b0,1'b0,1'b0}));
        check("reset_retired", 64'(retired), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            @(negedge clk);
            opcode = vecs[i].op; funct = vecs[i].fn;
            zero_flag = vecs[i].zf; mem_bus.mem_ready = vecs[i].mr;
            #2 check($sformatf("row_%0d", i), 64'(outs()), 64'(vecs[i].exp));
        end
        exp_ret = 32'd7;
        @(posedge clk);
        #1 check("table_retired", 64'(retired), 64'(exp_ret));
        check("table_back_to_fetch", 64'(state), 64'd0);

        run_r(6'b100000, 4'b0010, 1'b1);
        run_r(6'b100010, 4'b0110, 1'b1);
        run_r(6'b100100, 4'b0000, 1'b1);
        run_r(6'b100101, 4'b0001, 1'b1);
        run_r(6'b100110, 4'b0011, 1'b1);
        run_r(6'b100111, 4'b0100, 1'b1);
        run_r(6'b101010, 4'b0111, 1'b1);
        run_r(6'b000000, 4'b1000, 1'b1);
        run_r(6'b000010, 4'b1001, 1'b1);
        run_r(6'b000011, 4'b1010, 1'b1);
        run_r(6'b000100, 4'b1011, 1'b1);
        run_r(6'b000110, 4'b1100, 1'b1);
        run_r(6'b000111, 4'b1101, 1'b1);
        run_r(6'b111111, 4'b0010, 1'b0);

        // illegal opcode retires from DECODE with no writes
        @(negedge clk);
        opcode = 6'b111111; funct = '0; mem_bus.mem_ready = 1'b1;
        #2 check("illegal_fetch", 64'(state), 64'd0);
        @(negedge clk);
        #2 check("illegal_decode",
                 64'({state, instr_done, reg_write, pc_en, ir_write, mem_bus.mem_req, mem_bus.mem_write}),
                 64'({4'd1, 1'b1, 5'b00000}));
        exp_ret = exp_ret + 32'd1;
        @(posedge clk);
        #1 check("illegal_next", 64'({state, retired}), 64'({4'd0, exp_ret}));

        // retired wraps on a completing j
        @(negedge clk);
        mem_bus.mem_ready = 1'b0; opcode = 6'b000010;
        force dut.retired = 32'hFFFF_FFFF;
        #1 release dut.retired;
        #1 check("wrap_preset", 64'(retired), 64'hFFFF_FFFF);
        @(negedge clk);
        mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 check("wrap_jump", 64'({state, pc_en, pc_src, instr_done}), 64'({4'd11, 1'b1, 2'b10, 1'b1}));
        @(posedge clk);
        #1 check("wrap_retired", 64'(retired), 64'd0);

        // reset in the middle of a MEMWR wait
        @(negedge clk);
        opcode = 6'b101011; mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_bus.mem_ready = 1'b0;
        #2 check("memwr_wait", 64'({state, mem_bus.mem_req, mem_bus.mem_write, mem_bus.iord, instr_done}),
                 64'({4'd5, 1'b1, 1'b1, 1'b1, 1'b0}));
        #1 rst_n = 1'b0;
        #1 check("abort_outs", 64'({state, mem_bus.mem_req, mem_bus.mem_write, mem_bus.iord, instr_done}),
                 64'({4'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
        check("abort_retired", 64'(retired), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_bus.mem_ready = 1'b1;
        #2 check("refetch", 64'({state, mem_bus.mem_req, ir_write, pc_en}), 64'({4'd0, 1'b1, 1'b1, 1'b1}));
        @(posedge clk);
        #1 check("refetch_decode", 64'(state), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
